// File: rtl/go_pkg.sv
// go_pkg: types and constants shared by the Go board blocks.
package go_pkg;

    localparam int unsigned BOARD_DIM = 9;

    // Highest legal row or column index on the board.
    localparam logic [3:0] POS_MAX = 4'(BOARD_DIM - 1);

    // Contents of one board cell.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    // A board position, packed as {row, col}.
    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } move_t;

    // Full board, indexed as board[row][col]. Row 0 is the top row.
    typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0][1:0] board_t;

endpackage

// File: rtl/move_entry_edge_detect.sv
// edge_detect: rising-edge pulse generator for one debounced button level.
// The pulse is combinational from the current level and the registered
// previous level, so the consuming logic can act on the edge in the same cycle.
module edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic level,
    output logic pulse
);

    logic prev;

    // Remember last cycle's level. Cleared by reset, so a button held through
    // reset produces one edge on the first cycle after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/move_entry.sv
// move_entry: cursor and move-entry controller for the 9x9 Go board.
// Turns button edges into cursor moves and legal placements, hands each move
// to board_updater with a one-cycle start_flag, waits for board_ready (or a
// timeout), then alternates the side to move.
// Build option: define MOVE_ENTRY_WRAP_EN to make the cursor wrap around the
// board edges; by default it saturates at 0 and 8.
module move_entry
    import go_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65_000,
    parameter int unsigned START_ROW      = 4,
    parameter int unsigned START_COL      = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  board_t     board,
    input  logic       board_ready,
    output logic       start_flag,
    output logic [7:0] move,
    output logic       turn,
    output logic [3:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       busy,
    output logic       illegal,
    output logic       timeout
);

    // FSM encoding kept as plain constants for compatibility with older tools.
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_UPD = 2'd2;

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] ROW_RST = 4'(START_ROW);
    localparam logic [3:0] COL_RST = 4'(START_COL);

    // One step towards index 0.
    function automatic logic [3:0] pos_dec(input logic [3:0] p);
`ifdef MOVE_ENTRY_WRAP_EN
        return (p == '0) ? POS_MAX : p - 4'd1;
`else
        return (p == '0) ? p : p - 4'd1;
`endif
    endfunction

    // One step towards index 8.
    function automatic logic [3:0] pos_inc(input logic [3:0] p);
`ifdef MOVE_ENTRY_WRAP_EN
        return (p >= POS_MAX) ? '0 : p + 4'd1;
`else
        return (p >= POS_MAX) ? p : p + 4'd1;
`endif
    endfunction

    logic e_up, e_down, e_left, e_right, e_place;

    edge_detect u_ed_up    (.clk_in(clk_in), .rst_in(rst_in), .level(btn_up),    .pulse(e_up));
    edge_detect u_ed_down  (.clk_in(clk_in), .rst_in(rst_in), .level(btn_down),  .pulse(e_down));
    edge_detect u_ed_left  (.clk_in(clk_in), .rst_in(rst_in), .level(btn_left),  .pulse(e_left));
    edge_detect u_ed_right (.clk_in(clk_in), .rst_in(rst_in), .level(btn_right), .pulse(e_right));
    edge_detect u_ed_place (.clk_in(clk_in), .rst_in(rst_in), .level(btn_place), .pulse(e_place));

    logic [1:0]       state,     state_nx;
    logic [CNT_W-1:0] cnt,       cnt_nx;
    move_t            move_q,    move_nx;
    logic [3:0]       row_nx,    col_nx;
    logic             turn_nx,   start_nx, busy_nx, illegal_nx, timeout_nx;
    logic             cell_empty;

    assign cell_empty = (board[cursor_row][cursor_col] == EMPTY);
    assign move       = move_q;

    // Next-state and next-output decode; every output is then registered below.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        move_nx    = move_q;
        row_nx     = cursor_row;
        col_nx     = cursor_col;
        turn_nx    = turn;
        start_nx   = 1'b0;
        illegal_nx = 1'b0;
        timeout_nx = 1'b0;

        case (state)
            IDLE: begin
                // Place has priority; a direction edge in the same cycle is dropped.
                if (e_place) begin
                    if (cell_empty) begin
                        move_nx.row = cursor_row;
                        move_nx.col = cursor_col;
                        state_nx    = ISSUE;
                    end else begin
                        illegal_nx = 1'b1;
                    end
                end else if (e_up) begin
                    row_nx = pos_dec(cursor_row);
                end else if (e_down) begin
                    row_nx = pos_inc(cursor_row);
                end else if (e_left) begin
                    col_nx = pos_dec(cursor_col);
                end else if (e_right) begin
                    col_nx = pos_inc(cursor_col);
                end
            end
            ISSUE: begin
                // board_ready is deliberately not looked at here: a level left
                // over from the previous move must not complete this one.
                start_nx = 1'b1;
                cnt_nx   = '0;
                state_nx = WAIT_UPD;
            end
            WAIT_UPD: begin
                if (board_ready) begin
                    turn_nx  = ~turn;
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State, cursor, move latch, counter and all registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            move_q     <= {ROW_RST, COL_RST};
            cursor_row <= ROW_RST;
            cursor_col <= COL_RST;
            turn       <= 1'b0;
            start_flag <= 1'b0;
            busy       <= 1'b0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            move_q     <= move_nx;
            cursor_row <= row_nx;
            cursor_col <= col_nx;
            turn       <= turn_nx;
            start_flag <= start_nx;
            busy       <= busy_nx;
            illegal    <= illegal_nx;
            timeout    <= timeout_nx;
        end
    end

endmodule
